// File: rtl/edgesynch_if.sv
// rtl/edgesynch_if.sv - async level input and qualified level/strobe outputs of edgesynch
interface edgesynch_if #(
  parameter int DBCNT_W = 4
);
  logic               ain;
  logic               en;
  logic [DBCNT_W-1:0] dbcnt;
  logic               d;
  logic               ld;
  logic               rise;
  logic               fall;
  logic               busy;

  modport master (
    output ain, en, dbcnt,
    input  d, ld, rise, fall, busy
  );

  modport slave (
    input  ain, en, dbcnt,
    output d, ld, rise, fall, busy
  );
endinterface

// File: rtl/edgesynch.sv
// rtl/edgesynch.sv - resynchronise, debounce and strobe one asynchronous level
module edgesynch #(
  parameter int STAGES  = 2,
  parameter int DBCNT_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  edgesynch_if.slave  bus
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_QUAL   = 1'b1
  } state_t;

  logic [STAGES-1:0]  r_sync;
  state_t             r_state;
  logic [DBCNT_W-1:0] r_cnt;
  logic               r_d;
  logic               r_ld;
  logic               r_rise;
  logic               r_fall;
  logic               r_busy;
  logic               w_sy;

  assign w_sy = r_sync[STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync  <= '0;
      r_state <= ST_STABLE;
      r_cnt   <= '0;
      r_d     <= 1'b0;
      r_ld    <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], bus.ain};
      r_ld   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        ST_STABLE: begin
          if (bus.en && (w_sy != r_d)) begin
            if (bus.dbcnt == '0) begin
              r_d    <= w_sy;
              r_ld   <= 1'b1;
              r_rise <= w_sy;
              r_fall <= ~w_sy;
            end else begin
              // dbcnt is sampled only on entry; later changes wait for the next candidate
              r_state <= ST_QUAL;
              r_cnt   <= bus.dbcnt;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_QUAL: begin
          if (!bus.en || (w_sy == r_d)) begin
            r_state <= ST_STABLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == DBCNT_W'(1)) begin
            r_d     <= w_sy;
            r_ld    <= 1'b1;
            r_rise  <= w_sy;
            r_fall  <= ~w_sy;
            r_state <= ST_STABLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - DBCNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_STABLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.d    = r_d;
  assign bus.ld   = r_ld;
  assign bus.rise = r_rise;
  assign bus.fall = r_fall;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_edgesynch.sv
// tb/tb_edgesynch.sv - directed self-checking bench for edgesynch
module tb_edgesynch;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  edgesynch_if #(.DBCNT_W(4)) bus ();

  edgesynch #(.STAGES(2), .DBCNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // observed outputs packed as {d, ld, rise, fall, busy}
  logic [4:0] outs;
  assign outs = {bus.d, bus.ld, bus.rise, bus.fall, bus.busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [4:0] exp);
    tick();
    chk(tag, {27'd0, outs}, {27'd0, exp});
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    bus.ain   = 1'b0;
    bus.en    = 1'b1;
    bus.dbcnt = 4'd0;
    tick();
    tick();
    chk("reset_state", {27'd0, outs}, 32'd0);
    reset = 1'b0;
    tick();
    tick();
    chk("idle", {27'd0, outs}, 32'd0);

    // dbcnt=0 rise, then fall
    bus.ain = 1'b1;
    step("t1_e1", 5'b00000);
    step("t1_e2", 5'b00000);
    step("t1_e3", 5'b11100);
    step("t1_e4", 5'b10000);
    bus.ain = 1'b0;
    step("t1f_e1", 5'b10000);
    step("t1f_e2", 5'b10000);
    step("t1f_e3", 5'b01010);
    step("t1f_e4", 5'b00000);

    // dbcnt=3 qualified rise
    bus.dbcnt = 4'd3;
    bus.ain   = 1'b1;
    step("t2_e1", 5'b00000);
    step("t2_e2", 5'b00000);
    step("t2_e3", 5'b00001);
    step("t2_e4", 5'b00001);
    step("t2_e5", 5'b00001);
    step("t2_e6", 5'b11100);
    step("t2_e7", 5'b10000);
    bus.dbcnt = 4'd0;
    bus.ain   = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t2_back0", {27'd0, outs}, 32'd0);

    // dbcnt=3 glitch two cycles wide is rejected
    bus.dbcnt = 4'd3;
    bus.ain   = 1'b1;
    step("t3_e1", 5'b00000);
    step("t3_e2", 5'b00000);
    bus.ain = 1'b0;
    step("t3_e3", 5'b00001);
    step("t3_e4", 5'b00001);
    step("t3_e5", 5'b00000);
    step("t3_e6", 5'b00000);
    step("t3_e7", 5'b00000);

    // dbcnt=2 abort via en, then requalify
    bus.dbcnt = 4'd2;
    bus.ain   = 1'b1;
    step("t4_e1", 5'b00000);
    step("t4_e2", 5'b00000);
    step("t4_e3", 5'b00001);
    bus.en = 1'b0;
    step("t4_e4", 5'b00000);
    step("t4_e5", 5'b00000);
    bus.en = 1'b1;
    step("t4_e6", 5'b00001);
    step("t4_e7", 5'b00001);
    step("t4_e8", 5'b11100);
    step("t4_e9", 5'b10000);
    bus.dbcnt = 4'd0;
    bus.ain   = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_back0", {27'd0, outs}, 32'd0);

    // dbcnt=2 async reset while busy
    bus.dbcnt = 4'd2;
    bus.ain   = 1'b1;
    step("t5_e1", 5'b00000);
    step("t5_e2", 5'b00000);
    step("t5_e3", 5'b00001);
    #1;
    reset   = 1'b1;
    bus.ain = 1'b0;
    #1;
    chk("t5_async_clr", {27'd0, outs}, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) step($sformatf("t5_post_e%0d", i), 5'b00000);

    // dbcnt=0 toggle 1,0,1 each held 4 cycles
    bus.dbcnt = 4'd0;
    bus.ain   = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      logic [4:0] e;
      e[4] = ((k >= 3) && (k < 7)) || (k >= 11);
      e[3] = (k == 3) || (k == 7) || (k == 11);
      e[2] = (k == 3) || (k == 11);
      e[1] = (k == 7);
      e[0] = 1'b0;
      step($sformatf("t6_e%0d", k), e);
      if (k == 4) bus.ain = 1'b0;
      if (k == 8) bus.ain = 1'b1;
    end

    // dbcnt at maximum: fall qualifies at E18 with no counter wrap
    bus.dbcnt = 4'd15;
    bus.ain   = 1'b0;
    step("t7_e1", 5'b10000);
    step("t7_e2", 5'b10000);
    step("t7_e3", 5'b10001);
    for (int k = 4; k < 17; k++) tick();
    step("t7_e17", 5'b10001);
    step("t7_e18", 5'b01010);
    step("t7_e19", 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
